// File: rtl/present_core.sv
// Iterative PRESENT encryption core: one round per clock with an on-chip key
// schedule, valid/ready handshakes on the plaintext input and ciphertext output.
module present_core #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      ptext,
  input  logic [KEY_W-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      ctext,
  output logic             busy
);

  if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
    $error("present_core: KEY_W must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_core: ROUNDS must lie in 1..31");
  end

  localparam int         RC_LSB  = (KEY_W == 80) ? 15 : 62;
  localparam logic [4:0] LAST_RC = 5'(ROUNDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
    return y;
  endfunction

  // Bit i goes to (16*i) mod 63; bit 63 is the fixed point of the permutation.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                  input logic [4:0]       rc);
    logic [KEY_W-1:0] r;
    r = (k << 61) | (k >> (KEY_W - 61));
    r[KEY_W-1 -: 4] = sbox(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) r[KEY_W-5 -: 4] = sbox(r[KEY_W-5 -: 4]);
    r[RC_LSB +: 5] = r[RC_LSB +: 5] ^ rc;
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [63:0]      s_q, s_d;
  logic [KEY_W-1:0] k_q, k_d;
  logic [4:0]       rc_q, rc_d;
  logic             in_ready_q, busy_q, out_valid_q;
  logic [63:0]      round_out;
  logic [KEY_W-1:0] k_next;

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    k_d       = k_q;
    rc_d      = rc_q;
    round_out = p_layer(sbox_layer(s_q ^ k_q[KEY_W-1 -: 64]));
    k_next    = key_update(k_q, rc_q);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = ptext;
          k_d     = key;
          rc_d    = 5'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        k_d = k_next;
        if (rc_q == LAST_RC) begin
          // Last round folds in the whitening key ROUNDS+1 straight away.
          s_d     = round_out ^ k_next[KEY_W-1 -: 64];
          state_d = DONE;
        end else begin
          s_d  = round_out;
          rc_d = rc_q + 5'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they change with it.
  always_ff @(posedge CK or posedge RN) begin
    if (RN) begin
      state_q     <= IDLE;
      s_q         <= '0;
      k_q         <= '0;
      rc_q        <= 5'd1;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      k_q         <= k_d;
      rc_q        <= rc_d;
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d == RUN);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign ctext     = s_q;

endmodule

// File: tb/tb_present_core.sv
// Directed bench for present_core: known-answer vectors (80/128-bit keys),
// backpressure, back-to-back accepts and asynchronous reset mid-run.
module tb_present_core;

  logic          CK = 1'b0;
  logic          RN = 1'b1;
  logic          sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [63:0]   ptext = '0;
  logic [127:0]  key = '0;

  logic          iv80, iv128, or80, or128;
  logic          in_ready80, out_valid80, busy80;
  logic          in_ready128, out_valid128, busy128;
  logic [63:0]   ctext80, ctext128;
  logic          cur_in_ready, cur_out_valid, cur_busy;
  logic [63:0]   cur_ctext;

  int            assert_cnt = 0;
  int            fail_cnt = 0;
  logic [63:0]   exp_q[$];

  localparam logic [127:0] K80_ONES = 128'(80'hFFFF_FFFF_FFFF_FFFF_FFFF);
  localparam logic [63:0]  P_ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  assign iv80  = in_valid & ~sel;
  assign iv128 = in_valid & sel;
  assign or80  = out_ready & ~sel;
  assign or128 = out_ready & sel;

  assign cur_in_ready  = sel ? in_ready128  : in_ready80;
  assign cur_out_valid = sel ? out_valid128 : out_valid80;
  assign cur_busy      = sel ? busy128      : busy80;
  assign cur_ctext     = sel ? ctext128     : ctext80;

  present_core #(.KEY_W(80), .ROUNDS(31)) u_dut80 (
    .CK(CK), .RN(RN), .in_valid(iv80), .in_ready(in_ready80),
    .ptext(ptext), .key(key[79:0]), .out_valid(out_valid80),
    .out_ready(or80), .ctext(ctext80), .busy(busy80)
  );

  present_core #(.KEY_W(128), .ROUNDS(31)) u_dut128 (
    .CK(CK), .RN(RN), .in_valid(iv128), .in_ready(in_ready128),
    .ptext(ptext), .key(key), .out_valid(out_valid128),
    .out_ready(or128), .ctext(ctext128), .busy(busy128)
  );

  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    assert (obs === exp)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // An empty scoreboard yields X so the comparison cannot pass.
  task automatic pop_check(input string tag);
    logic [63:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check_output(tag, cur_ctext, e);
  endtask

  task automatic apply_stimulus(input logic [63:0] p, input logic [127:0] k,
                                input logic [63:0] e, input string tag);
    int lat;
    int busy_cnt;
    check_output({tag, "_ready_before"}, 64'(cur_in_ready), 64'd1);
    ptext = p;
    key = k;
    in_valid = 1'b1;
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
    ptext = ~p;
    key = ~k;
    lat = 1;
    busy_cnt = 0;
    while (1) begin
      if (cur_busy) busy_cnt++;
      if (cur_out_valid || lat >= 100) break;
      tick();
      lat++;
    end
    check_output({tag, "_latency"}, 64'(lat), 64'd32);
    check_output({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd31);
    out_ready = 1'b1;
    pop_check({tag, "_ctext"});
    tick();
    out_ready = 1'b0;
    check_output({tag, "_ready_after"}, 64'(cur_in_ready), 64'd1);
    check_output({tag, "_valid_after"}, 64'(cur_out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int cyc;
    int nacc;
    int outs;
    int acc_cyc[2];
    logic accept_now;
    logic out_now;

    $display("[TB] reset state");
    tick();
    tick();
    check_output("rst_in_ready", 64'(in_ready80), 64'd1);
    check_output("rst_out_valid", 64'(out_valid80), 64'd0);
    check_output("rst_busy", 64'(busy80), 64'd0);
    check_output("rst_ctext", ctext80, 64'd0);
    RN = 1'b0;
    tick();

    $display("[TB] known-answer vectors");
    apply_stimulus(64'd0, 128'd0, 64'h5579C1387B228445, "kat80_p0_k0");
    apply_stimulus(64'd0, K80_ONES, 64'hE72C46C0F5945049, "kat80_p0_k1");
    apply_stimulus(P_ONES, 128'd0, 64'hA112FFC72F68417B, "kat80_p1_k0");
    apply_stimulus(P_ONES, K80_ONES, 64'h3333DCD3213210D2, "kat80_p1_k1");
    sel = 1'b1;
    apply_stimulus(64'd0, 128'd0, 64'h96DB702A2E6900AF, "kat128_p0_k0");
    sel = 1'b0;

    $display("[TB] backpressure and ignored input during RUN/DONE");
    ptext = 64'd0;
    key = 128'd0;
    in_valid = 1'b1;
    exp_q.push_back(64'h5579C1387B228445);
    tick();
    lat = 1;
    while (!out_valid80 && lat < 100) begin
      in_valid = 1'($urandom_range(0, 1));
      ptext = {$urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      tick();
      lat++;
    end
    check_output("bp_latency", 64'(lat), 64'd32);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i & 1);
      ptext = {$urandom, $urandom};
      tick();
      check_output("bp_valid_held", 64'(out_valid80), 64'd1);
      check_output("bp_ready_low", 64'(in_ready80), 64'd0);
      check_output("bp_ctext_held", ctext80, (exp_q.size() != 0) ? exp_q[0] : 'x);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    pop_check("bp_ctext");
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_output("bp_idle_ready", 64'(in_ready80), 64'd1);
    check_output("bp_no_accept", 64'(busy80), 64'd0);
    tick();

    $display("[TB] back-to-back accepts");
    ptext = 64'd0;
    key = K80_ONES;
    in_valid = 1'b1;
    out_ready = 1'b1;
    nacc = 0;
    outs = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    for (cyc = 0; cyc < 120; cyc++) begin
      accept_now = in_valid && in_ready80;
      out_now = out_valid80 && out_ready;
      if (accept_now) exp_q.push_back((nacc == 0) ? 64'hE72C46C0F5945049 : 64'hA112FFC72F68417B);
      if (out_now) begin
        pop_check("b2b_ctext");
        outs++;
      end
      tick();
      if (accept_now) begin
        if (nacc < 2) acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc == 1) begin
          ptext = P_ONES;
          key = 128'd0;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (outs == 2) break;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_output("b2b_outputs", 64'(outs), 64'd2);
    check_output("b2b_accepts", 64'(nacc), 64'd2);
    check_output("b2b_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd33);
    tick();

    $display("[TB] asynchronous reset mid-run");
    ptext = P_ONES;
    key = K80_ONES;
    in_valid = 1'b1;
    exp_q.push_back(64'h3333DCD3213210D2);
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    check_output("mid_busy_before", 64'(busy80), 64'd1);
    RN = 1'b1;
    #1;
    check_output("mid_rst_busy", 64'(busy80), 64'd0);
    check_output("mid_rst_in_ready", 64'(in_ready80), 64'd1);
    check_output("mid_rst_out_valid", 64'(out_valid80), 64'd0);
    check_output("mid_rst_ctext", ctext80, 64'd0);
    exp_q.delete();
    #1;
    RN = 1'b0;
    tick();
    apply_stimulus(64'd0, 128'd0, 64'h5579C1387B228445, "post_rst_p0_k0");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/present_core.md
Name: present_core

Overview:
- Iterative PRESENT block-cipher encryption core: one round per clock, on-chip key schedule, valid/ready handshakes on input and output.
- Successor to the fixed 80-bit state-register datapath.
- Parametrised in key width (80/128) and round count (reduced-round builds for analysis/test).
- Sits between the host-side block buffer and the ciphertext output FIFO.

Parameters:
- KEY_W, 80, key width; legal values 80 or 128 (any other value is a synthesis-time error).
- ROUNDS, 31, number of full rounds; legal range 1..31.

Ports:
- CK  input  1  clock, rising edge.
- RN  input  1  reset, asynchronous, active-high.
- in_valid  input  1  ptext/key valid.
- in_ready  output  1  core can accept a block.
- ptext  input  64  plaintext.
- key  input  KEY_W  cipher key.
- out_valid  output  1  ctext holds a finished ciphertext.
- out_ready  input  1  consumer accepts ctext.
- ctext  output  64  ciphertext; meaningful only while out_valid=1.
- busy  output  1  high in RUN.

Behaviour:
- Registers:
  - state S (64 bits).
  - key register K (KEY_W bits).
  - round counter rc (5 bits).
  - FSM with states IDLE, RUN, DONE.
- Reset (RN=1, asynchronous, any cycle including mid-RUN or DONE):
  - FSM=IDLE, S=0, K=0, rc=1.
  - Outputs: in_ready=1, out_valid=0, busy=0, ctext=0.
  - A pending result is discarded.
- Output decode:
  - in_ready=1 only in IDLE.
  - busy=1 only in RUN.
  - out_valid=1 only in DONE.
  - ctext=S at all times.
- IDLE:
  - On in_valid & in_ready: S<=ptext, K<=key, rc<=1, go to RUN.
  - Otherwise hold.
- RUN, each cycle:
  - RK = K[KEY_W-1:KEY_W-64].
  - T = pLayer(sBoxLayer(S ^ RK)).
  - K' = update(K, rc).
  - If rc<ROUNDS: S<=T, K<=K', rc<=rc+1.
  - If rc==ROUNDS: S<=T ^ K'[KEY_W-1:KEY_W-64] (final whitening with round key ROUNDS+1), K<=K', go to DONE.
  - in_valid is ignored throughout RUN.
- DONE:
  - S is held stable.
  - On out_ready: go to IDLE.
  - A new block cannot be accepted in the same cycle as the DONE->IDLE transition.
- Latency: accept edge to out_valid=1 is exactly ROUNDS+1 rising edges. Minimum block period is ROUNDS+2 cycles.
- S-box (4-bit, input 0..F): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2. sBoxLayer applies it to all 16 nibbles.
- pLayer:
  - Bit i of the input moves to position (16*i) mod 63 for i=0..62.
  - Bit 63 stays at 63.
  - Purely combinational wiring.
- Key update, 80-bit:
  - K = K rotated left by 61.
  - Then K[79:76] = S(K[79:76]).
  - Then K[19:15] ^= rc.
- Key update, 128-bit:
  - K = K rotated left by 61.
  - Then K[127:124] = S(K[127:124]) and K[123:120] = S(K[123:120]).
  - Then K[66:62] ^= rc.
- rc is 5 bits; ROUNDS<=31 guarantees rc never wraps.
- ptext and key are sampled only at the accept edge; later changes have no effect.

Test Plan:
- KEY_W=80, ROUNDS=31, ptext=0, key=0 -> ctext=5579C1387B228445. out_valid rises exactly 32 edges after accept; busy is high for 31 cycles.
- KEY_W=80, remaining known-answer vectors, each -> its ciphertext:
  - ptext=0, key=all-ones -> E72C46C0F5945049.
  - ptext=all-ones, key=0 -> A112FFC72F68417B.
  - ptext=all-ones, key=all-ones -> 3333DCD3213210D2.
- KEY_W=128, ptext=0, key=0 -> ctext=96DB702A2E6900AF.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> ctext and out_valid stay stable and in_ready stays 0. Toggle in_valid/ptext during RUN and DONE -> result unchanged, no second accept. Then out_ready=1 for one cycle -> IDLE with in_ready=1 on the next cycle.
- Back-to-back: hold in_valid=1 continuously with 2 vectors and out_ready=1 -> accepts are spaced exactly 33 cycles apart and both ciphertexts are correct.
- Reset mid-RUN: assert RN at rc=15 -> all outputs reset immediately (async, before the next edge). After release, ptext=0, key=0 -> 5579C1387B228445 with no residue from the aborted block.
